// File: rtl/inst_cache_pkg.sv
// Shared types and geometry constants for the direct-mapped instruction cache.
package icache_types;

    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned LINE_W   = BEATS * BEAT_W;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

endpackage

// File: rtl/inst_cache_line_array.sv
// Per-set valid/tag/data storage: asynchronous read, synchronous write,
// global valid clear and asynchronous reset of the valid bits.
module icache_line_array
    import icache_types::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_SETS),
    parameter int unsigned TAG_W    = 32 - OFFSET_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output line_t            rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  line_t            wr_data_i,
    input  logic             clr_all_i
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    line_t               data_q [NUM_SETS];

    // Valid bits: clear wins over a simultaneous install so an inval on the
    // last fill beat leaves the new line invalid too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage, written when a fill completes.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, 4-beat
// 64-bit line refill on a miss.
module inst_cache
    import icache_types::*;
#(
    parameter int unsigned NUM_SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_mem_read,
    input  logic [31:0] inst_mem_address,
    input  logic [3:0]  inst_mem_byte_enable,
    output logic [31:0] inst_mem_rdata,
    output logic        inst_mem_resp,
    input  logic        inval,
    output logic [31:0] pmem_address,
    output logic        pmem_read,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int unsigned IDX_W       = $clog2(NUM_SETS);
    localparam int unsigned TAG_W       = 32 - OFFSET_W - IDX_W;
    localparam int unsigned LINE_ADDR_W = TAG_W + IDX_W;

    state_t                 state_q;
    logic [1:0]             beat_q;
    logic [LINE_ADDR_W-1:0] miss_addr_q;
    line_t                  line_buf_q;
    line_t                  line_buf_d;
    logic                   pmem_read_q;

    logic [TAG_W-1:0]       addr_tag;
    logic [IDX_W-1:0]       addr_idx;
    logic [2:0]             addr_wsel;
    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    line_t                  rd_data;
    logic                   hit;
    logic                   fill_done;
    logic                   unused_bits;

    assign addr_tag  = inst_mem_address[31 -: TAG_W];
    assign addr_idx  = inst_mem_address[OFFSET_W +: IDX_W];
    assign addr_wsel = inst_mem_address[4:2];

    // Byte enables and the sub-word address bits carry no meaning for fetches.
    assign unused_bits = ^{inst_mem_byte_enable, inst_mem_address[1:0]};

    icache_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (addr_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_done),
        .wr_idx_i   (miss_addr_q[IDX_W-1:0]),
        .wr_tag_i   (miss_addr_q[LINE_ADDR_W-1 -: TAG_W]),
        .wr_data_i  (line_buf_d),
        .clr_all_i  (inval)
    );

    assign hit       = rd_valid && (rd_tag == addr_tag);
    assign fill_done = (state_q == FILL) && pmem_resp && (beat_q == 2'(BEATS - 1));

    // Line buffer with the incoming beat merged in; the array is written from
    // this so the final beat lands in the same edge as the install.
    always_comb begin
        line_buf_d = line_buf_q;
        line_buf_d[{beat_q, 6'd0} +: BEAT_W] = pmem_rdata;
    end

    // Miss/refill FSM with beat counter, latched miss line address and burst request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            miss_addr_q <= '0;
            line_buf_q  <= '0;
            pmem_read_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_mem_read && !hit) begin
                        miss_addr_q <= {addr_tag, addr_idx};
                        beat_q      <= '0;
                        pmem_read_q <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        line_buf_q <= line_buf_d;
                        beat_q     <= beat_q + 2'd1;
                        if (fill_done) begin
                            pmem_read_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    pmem_read_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign pmem_read      = pmem_read_q;
    assign pmem_address   = {miss_addr_q, {OFFSET_W{1'b0}}};
    assign inst_mem_resp  = (state_q == IDLE) && inst_mem_read && hit;
    assign inst_mem_rdata = inst_mem_resp ? rd_data[{addr_wsel, 5'd0} +: 32] : '0;

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: a stimulus process issues fetches and
// queues expected responses, a behavioural memory serves bursts, and a
// monitor checks every response the cache presents.
`timescale 1ns/1ps
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_mem_read;
    logic [31:0] inst_mem_address;
    logic [3:0]  inst_mem_byte_enable;
    logic [31:0] inst_mem_rdata;
    logic        inst_mem_resp;
    logic        inval;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fill_q[$];
    int          errors = 0;
    int          checks = 0;
    int          gap_cfg [0:4] = '{default: 0};

    int          beat;
    int          gapleft;
    bit          inburst;
    logic [31:0] cur_line;

    always #5 clk = ~clk;

    inst_cache #(.NUM_SETS(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_mem_read        (inst_mem_read),
        .inst_mem_address     (inst_mem_address),
        .inst_mem_byte_enable (inst_mem_byte_enable),
        .inst_mem_rdata       (inst_mem_rdata),
        .inst_mem_resp        (inst_mem_resp),
        .inval                (inval),
        .pmem_address         (pmem_address),
        .pmem_read            (pmem_read),
        .pmem_rdata           (pmem_rdata),
        .pmem_resp            (pmem_resp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: word k of line L is k*0x11111111 xor (L - 0x40).
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] base;
        logic [31:0] k;
        base = {a[31:5], 5'b0};
        k    = {29'd0, a[4:2]};
        return (k * 32'h1111_1111) ^ (base - 32'h40);
    endfunction

    function automatic logic [63:0] beat_data(input logic [31:0] line, input int k);
        logic [31:0] a;
        a = line + 32'(8 * k);
        return {word_at(a + 32'd4), word_at(a)};
    endfunction

    // Behavioural physical memory: serves bursts with per-beat idle gaps and
    // checks the burst address and request hold against the queued fill.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        inburst    = 1'b0;
        beat       = 0;
        gapleft    = 0;
        cur_line   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                inburst   = 1'b0;
                beat      = 0;
                pmem_resp = 1'b0;
            end else begin
                if (inburst && pmem_resp) beat++;
                pmem_resp = 1'b0;
                if (inburst && beat == 4) begin
                    chk("pmem_read_drop", 64'(pmem_read), 64'd0);
                    inburst = 1'b0;
                end else if (inburst) begin
                    chk("pmem_read_hold", 64'(pmem_read), 64'd1);
                end
                if (pmem_read && !inburst) begin
                    inburst = 1'b1;
                    beat    = 0;
                    gapleft = gap_cfg[0];
                    if (fill_q.size() == 0) begin
                        chk("unexpected_fill", 64'(pmem_address), 64'hFFFF_FFFF_FFFF_FFFF);
                        cur_line = pmem_address;
                    end else begin
                        cur_line = fill_q.pop_front();
                    end
                end
                if (inburst && pmem_read) begin
                    chk("pmem_address", 64'(pmem_address), 64'(cur_line));
                    if (gapleft > 0) begin
                        gapleft--;
                    end else begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = beat_data(cur_line, beat);
                        gapleft    = gap_cfg[beat + 1];
                    end
                end
            end
        end
    end

    // Response monitor: every presented response must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (inst_mem_resp) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'(inst_mem_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("resp_addr", 64'(inst_mem_address), 64'(e.addr));
                chk("resp_data", 64'(inst_mem_rdata), 64'(e.data));
            end
        end else begin
            chk("rdata_idle_zero", 64'(inst_mem_rdata), 64'd0);
        end
    end

    // Issue a fetch and wait for its response; optional inval pulse and
    // mid-request address change at given cycle offsets.
    task automatic run_req(input logic [31:0] a, input logic [31:0] exp_data, input int lat,
                           input int inv_at, input int chg_at, input logic [31:0] a2,
                           input string name);
        int   n;
        exp_t e;
        inst_mem_read    = 1'b1;
        inst_mem_address = a;
        e.addr = (chg_at >= 0) ? a2 : a;
        e.data = exp_data;
        exp_q.push_back(e);
        n = 0;
        forever begin
            if (n == chg_at) inst_mem_address = a2;
            inval = (n == inv_at);
            @(negedge clk);
            if (inst_mem_resp) break;
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                void'(exp_q.pop_back());
                break;
            end
        end
        chk({name, "_latency"}, 64'(n), 64'(lat));
        @(posedge clk);
        #1;
        inval = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst                  = 1'b0;
        inst_mem_read        = 1'b0;
        inst_mem_address     = '0;
        inst_mem_byte_enable = 4'hF;
        inval                = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp", 64'(inst_mem_resp), 64'd0);
        chk("reset_rdata", 64'(inst_mem_rdata), 64'd0);
        chk("reset_pmem_read", 64'(pmem_read), 64'd0);
        chk("reset_pmem_address", 64'(pmem_address), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss then same-cycle hits in the installed line.
        fill_q.push_back(32'h0000_0040);
        run_req(32'h0000_0040, 32'h0000_0000, 5, -1, -1, '0, "cold_miss");
        run_req(32'h0000_0044, 32'h1111_1111, 0, -1, -1, '0, "hit_44");
        run_req(32'h0000_0048, 32'h2222_2222, 0, -1, -1, '0, "hit_48");

        // Conflict on index 2.
        fill_q.push_back(32'h0000_0240);
        run_req(32'h0000_0240, 32'h0000_0200, 5, -1, -1, '0, "conflict_240");
        fill_q.push_back(32'h0000_0040);
        run_req(32'h0000_0040, 32'h0000_0000, 5, -1, -1, '0, "conflict_40");

        // Abandoned request: 0x100 misses, CPU moves to resident 0x200.
        fill_q.push_back(32'h0000_0200);
        run_req(32'h0000_0200, 32'h0000_01C0, 5, -1, -1, '0, "fill_200");
        fill_q.push_back(32'h0000_0100);
        run_req(32'h0000_0100, 32'h0000_01C0, 5, -1, 2, 32'h0000_0200, "abandon");
        run_req(32'h0000_0100, 32'h0000_00C0, 0, -1, -1, '0, "hit_100");
        run_req(32'h0000_0104, 32'h1111_11D1, 0, -1, -1, '0, "hit_104");

        // inval on the 4th beat: line stays invalid and is refetched.
        fill_q.push_back(32'h0000_03C0);
        fill_q.push_back(32'h0000_03C0);
        run_req(32'h0000_03C0, 32'h0000_0380, 10, 4, -1, '0, "inval_4th_beat");
        fill_q.push_back(32'h0000_0040);
        run_req(32'h0000_0040, 32'h0000_0000, 5, -1, -1, '0, "after_inval_40");
        fill_q.push_back(32'h0000_0200);
        run_req(32'h0000_0200, 32'h0000_01C0, 5, -1, -1, '0, "after_inval_200");
        fill_q.push_back(32'h0000_0100);
        run_req(32'h0000_0104, 32'h1111_11D1, 5, -1, -1, '0, "after_inval_104");

        // inval during an IDLE hit: hit answers, next access misses.
        run_req(32'h0000_03C4, 32'h1111_1291, 0, 0, -1, '0, "idle_inval_hit");
        fill_q.push_back(32'h0000_03C0);
        run_req(32'h0000_03C0, 32'h0000_0380, 5, -1, -1, '0, "post_idle_inval");

        // Stalled memory: gaps 1,3,0,2 ahead of beats 0..3.
        gap_cfg = '{1, 3, 0, 2, 0};
        fill_q.push_back(32'h0000_04E0);
        run_req(32'h0000_04E0, 32'h0000_04A0, 11, -1, -1, '0, "stall_w0");
        gap_cfg = '{default: 0};
        run_req(32'h0000_04E4, 32'h1111_15B1, 0, -1, -1, '0, "stall_w1");
        run_req(32'h0000_04E8, 32'h2222_2682, 0, -1, -1, '0, "stall_w2");
        run_req(32'h0000_04EC, 32'h3333_3793, 0, -1, -1, '0, "stall_w3");
        run_req(32'h0000_04F0, 32'h4444_40E4, 0, -1, -1, '0, "stall_w4");
        run_req(32'h0000_04F4, 32'h5555_51F5, 0, -1, -1, '0, "stall_w5");
        run_req(32'h0000_04F8, 32'h6666_62C6, 0, -1, -1, '0, "stall_w6");
        run_req(32'h0000_04FC, 32'h7777_73D7, 0, -1, -1, '0, "stall_w7");

        // Reset during beat 2 of a burst.
        fill_q.push_back(32'h0000_0520);
        inst_mem_read    = 1'b1;
        inst_mem_address = 32'h0000_0520;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_pmem_read", 64'(pmem_read), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_reset_pmem_read", 64'(pmem_read), 64'd0);
        chk("mid_reset_resp", 64'(inst_mem_resp), 64'd0);
        inst_mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill_q.push_back(32'h0000_0520);
        run_req(32'h0000_0520, 32'h0000_04E0, 5, -1, -1, '0, "post_reset_520");
        fill_q.push_back(32'h0000_04E0);
        run_req(32'h0000_04E0, 32'h0000_04A0, 5, -1, -1, '0, "post_reset_4e0");
        fill_q.push_back(32'h0000_0040);
        run_req(32'h0000_0044, 32'h1111_1111, 5, -1, -1, '0, "post_reset_44");

        inst_mem_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("fill_queue_drained", 64'(fill_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
